// File: rtl/axil_periph_slave_if.sv
// AXI-lite bus bundle between the data-bus demux master port and the peripheral bank.
interface axil_periph_slave_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_periph_slave.sv
// AXI-lite peripheral register bank: scratch, GPIO out/in, 64-bit cycle timer, ID.
module axil_periph_slave #(
    parameter int unsigned GPIO_W     = 8,
    parameter logic [31:0] ID_VALUE   = 32'h5256_0001,
    // Reset value of the timer; zero in normal use.
    parameter logic [63:0] MTIME_INIT = 64'd0
) (
    input  logic              clk,
    input  logic              rstf,
    axil_periph_slave_if.slave s_axi,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in
);
    localparam int unsigned OFF_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned TIME_W = 64;

    localparam logic [OFF_W-1:0] OFF_SCRATCH  = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_GPIO_OUT = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_GPIO_IN  = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_MTIME_LO = OFF_W'(3);
    localparam logic [OFF_W-1:0] OFF_MTIME_HI = OFF_W'(4);
    localparam logic [OFF_W-1:0] OFF_ID       = OFF_W'(5);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-path holding registers and response state
    logic              aw_held;
    logic [OFF_W-1:0]  aw_off_q;
    logic              w_held;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    // Read-path response state
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    // Register contents
    logic [DATA_W-1:0] scratch_q;
    logic [GPIO_W-1:0] gpio_q;
    logic [GPIO_W-1:0] gpio_sync1;
    logic [GPIO_W-1:0] gpio_sync2;
    logic [TIME_W-1:0] mtime;
    logic [DATA_W-1:0] hi_snap;

    // Handshake and decode signals
    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic [OFF_W-1:0]  wr_off;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_ok;
    logic [DATA_W-1:0] scratch_nxt;
    logic [GPIO_W-1:0] gpio_nxt;
    logic [OFF_W-1:0]  rd_off;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;

    // Address bits outside the decoded offset are deliberately ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.awaddr[31:8], s_axi.awaddr[1:0],
                                s_axi.araddr[31:8], s_axi.araddr[1:0]};

    assign s_axi.awready = !aw_held && !bvalid_q;
    assign s_axi.wready  = !w_held && !bvalid_q;
    assign s_axi.arready = !rvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign gpio_out      = gpio_q;

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid && s_axi.wready;
    assign ar_hs = s_axi.arvalid && s_axi.arready;

    // Write decode: merge held and same-cycle AW/W, apply byte strobes
    always_comb begin
        wr_off      = aw_held ? aw_off_q : s_axi.awaddr[7:2];
        wr_data     = w_held ? w_data_q : s_axi.wdata;
        wr_strb     = w_held ? w_strb_q : s_axi.wstrb;
        commit      = (aw_held || aw_hs) && (w_held || w_hs);
        wr_ok       = (wr_off == OFF_SCRATCH) || (wr_off == OFF_GPIO_OUT);
        scratch_nxt = scratch_q;
        gpio_nxt    = gpio_q;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) begin
                scratch_nxt[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        for (int unsigned i = 0; i < GPIO_W; i++) begin
            if (wr_strb[i/8]) begin
                gpio_nxt[i] = wr_data[i];
            end
        end
    end

    // Read decode: register map mux with SLVERR for unmapped offsets
    always_comb begin
        rd_off  = s_axi.araddr[7:2];
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_off)
            OFF_SCRATCH:  rd_data = scratch_q;
            OFF_GPIO_OUT: rd_data = DATA_W'(gpio_q);
            OFF_GPIO_IN:  rd_data = DATA_W'(gpio_sync2);
            OFF_MTIME_LO: rd_data = mtime[31:0];
            OFF_MTIME_HI: rd_data = hi_snap;
            OFF_ID:       rd_data = ID_VALUE;
            default:      rd_err  = 1'b1;
        endcase
    end

    // Write channel: hold AW/W independently, commit when both present, hold B until bready
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            aw_held  <= 1'b0;
            aw_off_q <= '0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_off_q <= s_axi.awaddr[7:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end
            if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // RW register update on commit
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            scratch_q <= '0;
            gpio_q    <= '0;
        end else if (commit) begin
            if (wr_off == OFF_SCRATCH) begin
                scratch_q <= scratch_nxt;
            end
            if (wr_off == OFF_GPIO_OUT) begin
                gpio_q <= gpio_nxt;
            end
        end
    end

    // Read channel: register response on AR, snapshot timer high word on MTIME_LO
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            hi_snap  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            if (rd_off == OFF_MTIME_LO) begin
                hi_snap <= mtime[63:32];
            end
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // Free-running cycle timer
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            mtime <= MTIME_INIT;
        end else begin
            mtime <= mtime + TIME_W'(1);
        end
    end

    // Two-flop synchronizer for asynchronous GPIO inputs
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
        end
    end
endmodule

// File: tb/tb_axil_periph_slave.sv
// Bench for axil_periph_slave: transaction-level register-bank model plus directed vectors.
module tb_axil_periph_slave;
    localparam int unsigned GW         = 8;
    localparam logic [31:0] ID_V       = 32'h5256_0001;
    localparam logic [63:0] MT_INIT    = 64'h0000_0000_FFFF_FE00;
    localparam int          TMO        = 50;

    logic          clk = 1'b0;
    logic          rstf = 1'b0;
    logic [GW-1:0] gpio_out;
    logic [GW-1:0] gpio_in = '0;
    logic          chk_en = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    axil_periph_slave_if bus();

    axil_periph_slave #(.GPIO_W(GW), .ID_VALUE(ID_V), .MTIME_INIT(MT_INIT)) dut (
        .clk(clk), .rstf(rstf), .s_axi(bus.slave), .gpio_out(gpio_out), .gpio_in(gpio_in)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- model: register bank as seen by transactions ----------------
    logic [31:0]   m_scratch, m_gpio, m_hi;
    logic [63:0]   m_mtime;
    logic [GW-1:0] gin_hist [2];
    logic          m_awh, m_wh, m_bvalid, m_rvalid;
    logic [31:0]   m_awaddr, m_wdata, m_rdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    m_bresp, m_rresp;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // {slverr, data} of a read at word index w, given current bank contents
    function automatic logic [32:0] m_read(input int w);
        case (w)
            0: return {1'b0, m_scratch};
            1: return {1'b0, m_gpio};
            2: return {1'b0, 32'(gin_hist[1])};
            3: return {1'b0, m_mtime[31:0]};
            4: return {1'b0, m_hi};
            5: return {1'b0, ID_V};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    always @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            m_scratch <= '0; m_gpio <= '0; m_hi <= '0; m_mtime <= MT_INIT;
            gin_hist[0] <= '0; gin_hist[1] <= '0;
            m_awh <= 1'b0; m_wh <= 1'b0; m_bvalid <= 1'b0; m_rvalid <= 1'b0;
            m_awaddr <= '0; m_wdata <= '0; m_wstrb <= '0;
            m_bresp <= 2'b00; m_rresp <= 2'b00; m_rdata <= '0;
        end else begin : step
            automatic logic aw_take, w_take, ar_take;
            automatic logic [31:0] wa, wd;
            automatic logic [3:0] ws;
            automatic logic [32:0] rv;
            automatic int widx, ridx;
            aw_take = bus.awvalid && !m_awh && !m_bvalid;
            w_take  = bus.wvalid && !m_wh && !m_bvalid;
            ar_take = bus.arvalid && !m_rvalid;
            wa = m_awh ? m_awaddr : bus.awaddr;
            wd = m_wh ? m_wdata : bus.wdata;
            ws = m_wh ? m_wstrb : bus.wstrb;
            widx = int'(wa[7:0]) / 4;
            ridx = int'(bus.araddr[7:0]) / 4;
            rv = m_read(ridx);
            if (ar_take) begin
                m_rvalid <= 1'b1;
                m_rdata  <= rv[31:0];
                m_rresp  <= rv[32] ? 2'b10 : 2'b00;
                if (ridx == 3) m_hi <= m_mtime[63:32];
            end else if (m_rvalid && bus.rready) begin
                m_rvalid <= 1'b0;
            end
            if ((m_awh || aw_take) && (m_wh || w_take)) begin
                m_awh <= 1'b0; m_wh <= 1'b0; m_bvalid <= 1'b1;
                m_bresp <= (widx <= 1) ? 2'b00 : 2'b10;
                if (widx == 0) m_scratch <= merge(m_scratch, wd, ws);
                if (widx == 1) m_gpio <= merge(m_gpio, wd, ws) & 32'(GW == 32 ? 32'hFFFF_FFFF : (32'h1 << GW) - 1);
            end else begin
                if (aw_take) begin m_awh <= 1'b1; m_awaddr <= bus.awaddr; end
                if (w_take) begin m_wh <= 1'b1; m_wdata <= bus.wdata; m_wstrb <= bus.wstrb; end
                if (m_bvalid && bus.bready) m_bvalid <= 1'b0;
            end
            m_mtime <= m_mtime + 64'd1;
            gin_hist[0] <= gpio_in;
            gin_hist[1] <= gin_hist[0];
        end
    end

    // Compare DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("awready", 64'(bus.awready), 64'(!m_awh && !m_bvalid));
            check("wready",  64'(bus.wready),  64'(!m_wh && !m_bvalid));
            check("arready", 64'(bus.arready), 64'(!m_rvalid));
            check("bvalid",  64'(bus.bvalid),  64'(m_bvalid));
            check("rvalid",  64'(bus.rvalid),  64'(m_rvalid));
            check("gpio_out", 64'(gpio_out), 64'(m_gpio[GW-1:0]));
            if (m_bvalid) check("bresp", 64'(bus.bresp), 64'(m_bresp));
            if (m_rvalid) begin
                check("rdata", 64'(bus.rdata), 64'(m_rdata));
                check("rresp", 64'(bus.rresp), 64'(m_rresp));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_aw(input logic [31:0] a, input int dly);
        int n;
        repeat (dly) tick();
        bus.awaddr = a; bus.awvalid = 1'b1;
        @(negedge clk); n = 0;
        while (!bus.awready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) check("aw_timeout", 64'd1, 64'd0);
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int n;
        repeat (dly) tick();
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        @(negedge clk); n = 0;
        while (!bus.wready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) check("w_timeout", 64'd1, 64'd0);
        tick();
        bus.wvalid = 1'b0;
    endtask

    task automatic recv_b(input int hold, output logic [1:0] resp);
        int n;
        n = 0;
        while (!bus.bvalid && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) check("b_timeout", 64'd1, 64'd0);
        resp = bus.bresp;
        repeat (hold) begin
            check("awready_low_during_b", 64'(bus.awready), 64'd0);
            check("wready_low_during_b",  64'(bus.wready),  64'd0);
            @(negedge clk);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int hold, output logic [1:0] resp);
        fork
            send_aw(a, awd);
            send_w(d, s, wd);
        join
        recv_b(hold, resp);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        bus.araddr = a; bus.arvalid = 1'b1;
        @(negedge clk); n = 0;
        while (!bus.arready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) check("ar_timeout", 64'd1, 64'd0);
        tick();
        bus.arvalid = 1'b0;
        @(negedge clk); n = 0;
        while (!bus.rvalid && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) check("r_timeout", 64'd1, 64'd0);
        d = bus.rdata; r = bus.rresp;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp, rr;
        logic [31:0] rd, lo1, lo2;
        int n;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) tick();
        rstf = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_awready", 64'(bus.awready), 64'd1);
        check("rst_arready", 64'(bus.arready), 64'd1);
        check("rst_bvalid",  64'(bus.bvalid),  64'd0);
        check("rst_gpio_out", 64'(gpio_out), 64'd0);
        tick();

        // Full-word write then read back
        do_write(32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp);
        check("wr_scratch_bresp", 64'(resp), 64'd0);
        do_read(32'h0000_0000, rd, rr);
        check("rd_scratch", 64'(rd), 64'hDEAD_BEEF);
        check("rd_scratch_rresp", 64'(rr), 64'd0);

        // Byte strobes, then GPIO_OUT width masking
        do_write(32'h0000_0000, 32'h1122_3344, 4'b0101, 0, 0, 0, resp);
        do_read(32'h0000_0003, rd, rr);
        check("rd_scratch_strb", 64'(rd), 64'hDE22_BE44);
        do_write(32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp);
        check("gpio_out_ff", 64'(gpio_out), 64'hFF);
        do_read(32'hFFFF_FF04, rd, rr);
        check("rd_gpio_out", 64'(rd), 64'h0000_00FF);

        // AW leads W by 3, then W leads AW by 3; bready held low 4 cycles
        do_write(32'h0000_0000, 32'hCAFE_F00D, 4'hF, 0, 3, 4, resp);
        check("aw_first_bresp", 64'(resp), 64'd0);
        do_read(32'h0000_0000, rd, rr);
        check("rd_aw_first", 64'(rd), 64'hCAFE_F00D);
        do_write(32'h0000_0004, 32'h0000_005A, 4'hF, 3, 0, 4, resp);
        do_read(32'h0000_0004, rd, rr);
        check("rd_w_first", 64'(rd), 64'h0000_005A);

        // wstrb=0 is a no-op with OKAY
        do_write(32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, resp);
        check("strb0_bresp", 64'(resp), 64'd0);
        do_read(32'h0000_0000, rd, rr);
        check("strb0_unchanged", 64'(rd), 64'hCAFE_F00D);

        // Same-edge read and write of SCRATCH: read sees the old value
        fork
            do_write(32'h0000_0000, 32'h1234_5678, 4'hF, 0, 0, 0, resp);
            do_read(32'h0000_0000, rd, rr);
        join
        check("same_edge_old", 64'(rd), 64'hCAFE_F00D);
        do_read(32'h0000_0000, rd, rr);
        check("same_edge_new", 64'(rd), 64'h1234_5678);

        // RO / unmapped accesses
        do_write(32'h0000_0014, 32'h0, 4'hF, 0, 0, 0, resp);
        check("wr_id_slverr", 64'(resp), 64'd2);
        do_write(32'h0000_0040, 32'h0, 4'hF, 0, 0, 0, resp);
        check("wr_unmapped_slverr", 64'(resp), 64'd2);
        do_read(32'h0000_0014, rd, rr);
        check("rd_id", 64'(rd), 64'h5256_0001);
        check("rd_id_rresp", 64'(rr), 64'd0);
        do_read(32'h0000_0040, rd, rr);
        check("rd_unmapped_data", 64'(rd), 64'd0);
        check("rd_unmapped_rresp", 64'(rr), 64'd2);

        // Timer: LO read just before the 32-bit carry, HI read after it
        n = 0;
        while (m_mtime[31:0] < 32'hFFFF_FFF0 && n < 2000) begin tick(); n++; end
        if (n >= 2000) check("mtime_wait_timeout", 64'd1, 64'd0);
        do_read(32'h0000_000C, lo1, rr);
        check("mtime_lo_pre_carry", 64'(lo1[31:8]), 64'hFF_FFFF);
        repeat (30) tick();
        do_read(32'h0000_0010, rd, rr);
        check("mtime_hi_snapshot", 64'(rd), 64'd0);
        do_read(32'h0000_000C, lo2, rr);
        check("mtime_lo_post_carry_small", 64'(lo2 < 32'd256), 64'd1);
        do_read(32'h0000_0010, rd, rr);
        check("mtime_hi_after_carry", 64'(rd), 64'd1);

        // GPIO input through the synchronizer
        gpio_in = 8'hA5;
        repeat (2) tick();
        do_read(32'h0000_0008, rd, rr);
        check("rd_gpio_in", 64'(rd), 64'h0000_00A5);

        // Reset while a write response is pending
        fork
            send_aw(32'h0000_0000, 0);
            send_w(32'hAAAA_5555, 4'hF, 0);
        join
        @(negedge clk); n = 0;
        while (!bus.bvalid && n < TMO) begin @(negedge clk); n++; end
        check("bvalid_pending", 64'(bus.bvalid), 64'd1);
        tick();
        rstf = 1'b0;
        #1;
        check("rst_clears_bvalid", 64'(bus.bvalid), 64'd0);
        check("rst_clears_gpio", 64'(gpio_out), 64'd0);
        tick();
        rstf = 1'b1;
        tick();
        do_read(32'h0000_0000, rd, rr);
        check("scratch_after_reset", 64'(rd), 64'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
